// File: rtl/delay_scan_sequencer.sv
// Automatic eye-scan controller: per masked link, sweeps the manual input delay,
// measures bit-align errors at each point and applies the centre of the widest clean window.
module delay_scan_sequencer #(
  parameter int NLINKS        = 12,
  parameter int STEP          = 8,
  parameter int DELAY_MAX     = 511,
  parameter int SETTLE_CYCLES = 16,
  parameter int DWELL_CYCLES  = 1024,
  parameter int RDY_TIMEOUT   = 4096,
  parameter int ERR_THRESH    = 0
) (
  input  logic                   clk160,
  input  logic                   IPIF_bus2ip_resetn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NLINKS-1:0]      link_mask,
  input  logic [NLINKS-1:0]      delay_ready,
  input  logic [NLINKS-1:0]      waiting_for_transitions,
  input  logic [NLINKS-1:0][15:0] bit_align_errors,
  output logic [NLINKS-1:0][8:0] scan_delay_in,
  output logic [NLINKS-1:0]      scan_delay_set,
  output logic [NLINKS-1:0]      scan_reset_counters,
  output logic                   busy,
  output logic                   done,
  output logic [NLINKS-1:0][8:0] result_delay,
  output logic [NLINKS-1:0][8:0] result_width,
  output logic [NLINKS-1:0]      result_valid,
  output logic [NLINKS-1:0]      scan_fail
);

  localparam int CNT_A   = (RDY_TIMEOUT > DWELL_CYCLES) ? RDY_TIMEOUT : DWELL_CYCLES;
  localparam int CNT_MAX = (CNT_A > SETTLE_CYCLES) ? CNT_A : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int LW      = (NLINKS > 1) ? $clog2(NLINKS) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_NEXT_LINK, S_APPLY, S_SET, S_SETTLE, S_WAIT_RDY, S_CLR, S_DWELL,
    S_SAMPLE, S_FINAL_APPLY, S_FINAL_SET, S_FINAL_SETTLE, S_FINAL_WAIT, S_DONE
  } state_t;

  state_t                  state_q;
  logic [NLINKS-1:0]       pending_q;
  logic [LW-1:0]           link_q;
  logic [9:0]              d_q;
  logic [CW-1:0]           cnt_q;
  logic [8:0]              run_start_q, best_start_q;
  logic [9:0]              run_len_q, best_len_q;
  logic [NLINKS-1:0][8:0]  delay_in_q, res_delay_q, res_width_q;
  logic [NLINKS-1:0]       set_q, rstc_q, res_valid_q, fail_q;
  logic                    busy_q, done_q;

  logic                    pick_found;
  logic [LW-1:0]           pick_idx;
  logic                    good_pt, last_pt, close_run;
  logic [9:0]              d_next;
  logic [8:0]              run_start_d, best_start_d;
  logic [9:0]              run_len_d, best_len_d;
  logic [17:0]             span, centre_wide;
  logic [8:0]              centre;

  // Lowest pending link wins: scan from the top so the last hit is the lowest index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NLINKS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        pick_found = 1'b1;
        pick_idx   = LW'(i);
      end
    end
  end

  assign good_pt = (bit_align_errors[link_q] <= 16'(ERR_THRESH)) && !waiting_for_transitions[link_q];
  assign d_next  = d_q + 10'(STEP);
  assign last_pt = d_next > 10'(DELAY_MAX);

  // Eye trackers after folding in the current point; the last point also closes an open run.
  always_comb begin
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    close_run    = !good_pt || last_pt;
    if (good_pt) begin
      if (run_len_q == '0) run_start_d = d_q[8:0];
      run_len_d = run_len_q + 10'd1;
    end
    if (close_run && (run_len_d > best_len_q)) begin
      best_start_d = run_start_d;
      best_len_d   = run_len_d;
    end
    if (close_run) run_len_d = '0;
  end

  always_comb begin
    span        = 18'(best_len_q - 10'd1) * 18'(STEP);
    centre_wide = 18'(best_start_q) + (span >> 1);
    if (best_len_q == '0)                    centre = '0;
    else if (centre_wide > 18'(DELAY_MAX))   centre = 9'(DELAY_MAX);
    else                                     centre = centre_wide[8:0];
  end

  always_ff @(posedge clk160 or negedge IPIF_bus2ip_resetn) begin
    if (!IPIF_bus2ip_resetn) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      link_q       <= '0;
      d_q          <= '0;
      cnt_q        <= '0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      delay_in_q   <= '0;
      set_q        <= '0;
      rstc_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      res_delay_q  <= '0;
      res_width_q  <= '0;
      res_valid_q  <= '0;
      fail_q       <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
      done_q <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        set_q   <= '0;
        rstc_q  <= '0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: if (start) begin
            pending_q   <= link_mask;
            res_valid_q <= '0;
            fail_q      <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_NEXT_LINK;
          end
          S_NEXT_LINK: if (pick_found) begin
            link_q              <= pick_idx;
            pending_q[pick_idx] <= 1'b0;
            run_start_q         <= '0;
            run_len_q           <= '0;
            best_start_q        <= '0;
            best_len_q          <= '0;
            d_q                 <= '0;
            state_q             <= S_APPLY;
          end else begin
            state_q <= S_DONE;
          end
          S_APPLY: begin
            set_q[link_q]      <= 1'b0;
            delay_in_q[link_q] <= d_q[8:0];
            state_q            <= S_SET;
          end
          S_FINAL_APPLY: begin
            set_q[link_q]      <= 1'b0;
            delay_in_q[link_q] <= centre;
            if (best_len_q == '0) fail_q[link_q] <= 1'b1;
            state_q            <= S_FINAL_SET;
          end
          S_SET, S_FINAL_SET: begin
            set_q[link_q] <= 1'b1;
            cnt_q         <= '0;
            state_q       <= (state_q == S_SET) ? S_SETTLE : S_FINAL_SETTLE;
          end
          S_SETTLE, S_FINAL_SETTLE: begin
            if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
              cnt_q   <= '0;
              state_q <= (state_q == S_SETTLE) ? S_WAIT_RDY : S_FINAL_WAIT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_WAIT_RDY, S_FINAL_WAIT: begin
            if (delay_ready[link_q]) begin
              cnt_q <= '0;
              if (state_q == S_WAIT_RDY) begin
                rstc_q[link_q] <= 1'b1;
                state_q        <= S_CLR;
              end else begin
                res_delay_q[link_q] <= centre;
                res_width_q[link_q] <= best_len_q[8:0];
                res_valid_q[link_q] <= !fail_q[link_q];
                state_q             <= S_NEXT_LINK;
              end
            end else if (cnt_q == CW'(RDY_TIMEOUT - 1)) begin
              // Link never became ready: skip it with its results untouched.
              fail_q[link_q] <= 1'b1;
              set_q[link_q]  <= 1'b0;
              cnt_q          <= '0;
              state_q        <= S_NEXT_LINK;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_CLR: begin
            if (cnt_q == CW'(1)) begin
              rstc_q[link_q] <= 1'b0;
              cnt_q          <= '0;
              state_q        <= S_DWELL;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_DWELL: begin
            if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
              cnt_q   <= '0;
              state_q <= S_SAMPLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_SAMPLE: begin
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            if (last_pt) begin
              state_q <= S_FINAL_APPLY;
            end else begin
              d_q     <= d_next;
              state_q <= S_APPLY;
            end
          end
          S_DONE: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign scan_delay_in       = delay_in_q;
  assign scan_delay_set      = set_q;
  assign scan_reset_counters = rstc_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign result_delay        = res_delay_q;
  assign result_width        = res_width_q;
  assign result_valid        = res_valid_q;
  assign scan_fail           = fail_q;

endmodule

// File: tb/tb_delay_scan_sequencer.sv
// Bench for delay_scan_sequencer: a 2-link datapath model answers with per-point errors,
// table-driven scans check results, hand sequences cover abort, timing and reset.
module tb_delay_scan_sequencer;

  localparam int NL     = 2;
  localparam int STEP   = 64;
  localparam int SETTLE = 4;
  localparam int DWELL  = 8;
  localparam int RTO    = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [NL-1:0] link_mask = '0;
  logic [NL-1:0] delay_ready, wft;
  logic [NL-1:0][15:0] errs;
  logic [NL-1:0][8:0] scan_delay_in, result_delay, result_width;
  logic [NL-1:0] scan_delay_set, rstc, result_valid, scan_fail;
  logic busy, done;

  // Datapath model: good/bad and no-transition flags per scan point (delay/64).
  logic [7:0]    good_pts [NL];
  logic [7:0]    wft_pts  [NL];
  logic [NL-1:0] rdy_en;
  logic [15:0]   err_bad;

  always #5 clk = ~clk;

  always_comb begin
    for (int l = 0; l < NL; l++) begin
      errs[l]        = good_pts[l][scan_delay_in[l][8:6]] ? 16'd0 : err_bad;
      wft[l]         = wft_pts[l][scan_delay_in[l][8:6]];
      delay_ready[l] = rdy_en[l] & scan_delay_set[l];
    end
  end

  delay_scan_sequencer #(
    .NLINKS(NL), .STEP(STEP), .DELAY_MAX(511), .SETTLE_CYCLES(SETTLE),
    .DWELL_CYCLES(DWELL), .RDY_TIMEOUT(RTO), .ERR_THRESH(0)
  ) dut (
    .clk160(clk), .IPIF_bus2ip_resetn(rst_n), .start(start), .abort(abort),
    .link_mask(link_mask), .delay_ready(delay_ready), .waiting_for_transitions(wft),
    .bit_align_errors(errs), .scan_delay_in(scan_delay_in), .scan_delay_set(scan_delay_set),
    .scan_reset_counters(rstc), .busy(busy), .done(done), .result_delay(result_delay),
    .result_width(result_width), .result_valid(result_valid), .scan_fail(scan_fail)
  );

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int done_base = 0;
  bit mon_en = 1'b0;
  int m_delay [NL];
  int m_width [NL];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) if (done) done_cnt++;

  // Handshake monitor on link 0: set low exactly one cycle per apply, counter clear
  // exactly two cycles, and DWELL_CYCLES+2 cycles from clear release to the next apply.
  int  rc_hi = 0, since = -1, set_lo = 0;
  bit  rc_prev = 1'b0, set_prev = 1'b0, had_high = 1'b0;
  always @(negedge clk) begin
    if (!mon_en) begin
      rc_hi = 0; since = -1; set_lo = 0; had_high = 1'b0;
    end else begin
      if (since >= 0) since++;
      if (rc_prev && !rstc[0]) begin
        check("clr_len", rc_hi, 2);
        rc_hi = 0;
        since = 0;
      end
      if (rstc[0]) rc_hi++;
      if (set_prev && !scan_delay_set[0]) begin
        if (since >= 0) check("dwell_to_apply", since, DWELL + 2);
        since = -1;
      end
      if (!scan_delay_set[0]) set_lo++;
      if (!set_prev && scan_delay_set[0]) begin
        if (had_high) check("set_low_len", set_lo, 1);
        had_high = 1'b1;
        set_lo = 0;
      end
    end
    rc_prev  = rstc[0];
    set_prev = scan_delay_set[0];
  end

  typedef struct {
    logic [1:0]  mask;
    logic [7:0]  good0, good1, wft0;
    logic [1:0]  rdy;
    logic [15:0] bad;
    logic [1:0]  exp_fail;
    logic [1:0]  exp_wr;
    logic [8:0]  dly0, wid0, dly1, wid1;
  } vec_t;

  vec_t vecs [8];

  task automatic pulse_start(input logic [NL-1:0] mask);
    @(posedge clk); #1;
    link_mask = mask;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == done_base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != done_base), 1);
    repeat (4) @(negedge clk);
    check({tag, "_done_once"}, done_cnt - done_base, 1);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic check_results(input string tag, input logic [1:0] exp_valid, input logic [1:0] exp_fail);
    check({tag, "_valid"}, 32'(result_valid), 32'(exp_valid));
    check({tag, "_fail"}, 32'(scan_fail), 32'(exp_fail));
    for (int l = 0; l < NL; l++) begin
      check($sformatf("%s_rdelay%0d", tag, l), 32'(result_delay[l]), m_delay[l]);
      check($sformatf("%s_rwidth%0d", tag, l), 32'(result_width[l]), m_width[l]);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_dly_in"}, 32'(scan_delay_in), 0);
    check({tag, "_set"}, 32'(scan_delay_set), 0);
    check({tag, "_rstc"}, 32'(rstc), 0);
    check({tag, "_rdelay"}, 32'(result_delay), 0);
    check({tag, "_rwidth"}, 32'(result_width), 0);
    check({tag, "_valid"}, 32'(result_valid), 0);
    check({tag, "_fail"}, 32'(scan_fail), 0);
  endtask

  initial begin
    vec_t v;
    int   falls;
    int   n;
    bit   rc_p;

    //            mask   good0  good1  wft0   rdy    bad     fail   wr     dly0 wid0 dly1 wid1
    vecs[0] = '{2'b01, 8'h3C, 8'h00, 8'h00, 2'b11, 16'd5, 2'b00, 2'b01, 9'd224, 9'd4, 9'd0,   9'd0};
    vecs[1] = '{2'b01, 8'h66, 8'h00, 8'h00, 2'b11, 16'd5, 2'b00, 2'b01, 9'd96,  9'd2, 9'd0,   9'd0};
    vecs[2] = '{2'b01, 8'h00, 8'h00, 8'h00, 2'b11, 16'd3, 2'b01, 2'b01, 9'd0,   9'd0, 9'd0,   9'd0};
    vecs[3] = '{2'b11, 8'h3C, 8'hFF, 8'h00, 2'b01, 16'd5, 2'b10, 2'b01, 9'd224, 9'd4, 9'd0,   9'd0};
    vecs[4] = '{2'b11, 8'hFF, 8'h80, 8'h00, 2'b11, 16'd5, 2'b00, 2'b11, 9'd224, 9'd8, 9'd448, 9'd1};
    vecs[5] = '{2'b10, 8'hFF, 8'h01, 8'h00, 2'b11, 16'd5, 2'b00, 2'b10, 9'd0,   9'd0, 9'd0,   9'd1};
    vecs[6] = '{2'b01, 8'hFF, 8'h00, 8'h08, 2'b11, 16'd5, 2'b00, 2'b01, 9'd352, 9'd4, 9'd0,   9'd0};
    vecs[7] = '{2'b01, 8'hAA, 8'h00, 8'h00, 2'b11, 16'd1, 2'b00, 2'b01, 9'd64,  9'd1, 9'd0,   9'd0};

    good_pts[0] = '0; good_pts[1] = '0;
    wft_pts[0]  = '0; wft_pts[1]  = '0;
    rdy_en  = '1;
    err_bad = 16'd5;
    for (int l = 0; l < NL; l++) begin
      m_delay[l] = 0;
      m_width[l] = 0;
    end

    repeat (3) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Empty mask: done two cycles after start, busy for exactly those two cycles.
    @(posedge clk); #1;
    link_mask = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("m0_busy_c1", 32'(busy), 1);
    check("m0_done_c1", 32'(done), 0);
    @(negedge clk);
    check("m0_done_c2", 32'(done), 0);
    @(negedge clk);
    check("m0_done_c3", 32'(done), 1);
    check("m0_busy_c3", 32'(busy), 0);
    @(negedge clk);
    check("m0_done_c4", 32'(done), 0);

    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      string tag;
      v = vecs[i];
      tag = $sformatf("v%0d", i);
      good_pts[0] = v.good0;
      good_pts[1] = v.good1;
      wft_pts[0]  = v.wft0;
      rdy_en      = v.rdy;
      err_bad     = v.bad;
      done_base   = done_cnt;
      pulse_start(v.mask);
      wait_done(tag);
      if (v.exp_wr[0]) begin m_delay[0] = v.dly0; m_width[0] = v.wid0; end
      if (v.exp_wr[1]) begin m_delay[1] = v.dly1; m_width[1] = v.wid1; end
      check_results(tag, v.exp_wr & ~v.exp_fail, v.exp_fail);
      for (int l = 0; l < NL; l++)
        if (v.exp_wr[l]) check($sformatf("%s_dly_in%0d", tag, l), 32'(scan_delay_in[l]), m_delay[l]);
      if (i == 0) begin
        check("v0_link1_dly_in", 32'(scan_delay_in[1]), 0);
        check("v0_link1_set", 32'(scan_delay_set[1]), 0);
      end
    end
    mon_en = 1'b0;

    // Abort during the third point's dwell (d=128).
    good_pts[0] = 8'h3C;
    good_pts[1] = 8'hFF;
    rdy_en      = '1;
    err_bad     = 16'd5;
    done_base   = done_cnt;
    pulse_start(2'b11);
    falls = 0;
    n = 0;
    rc_p = 1'b0;
    while (falls < 3 && n < 2000) begin
      @(negedge clk);
      if (rc_p && !rstc[0]) falls++;
      rc_p = rstc[0];
      n++;
    end
    check("abort_reach_dwell", falls, 3);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_set", 32'(scan_delay_set), 0);
    check("abort_rstc", 32'(rstc), 0);
    check("abort_dly_hold", 32'(scan_delay_in[0]), 128);
    check_results("abort", 2'b00, 2'b00);
    repeat (60) @(negedge clk);
    check("abort_no_done", done_cnt - done_base, 0);
    check("abort_stays_idle", 32'(busy), 0);

    // Clean rescan; a second start while busy must be ignored.
    done_base = done_cnt;
    pulse_start(2'b01);
    repeat (10) @(posedge clk);
    #1;
    link_mask = 2'b10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("rescan");
    m_delay[0] = 224;
    m_width[0] = 4;
    check_results("rescan", 2'b01, 2'b00);

    // start and abort together in IDLE: start wins.
    @(posedge clk); #1;
    link_mask = 2'b11;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("start_abort_busy", 32'(busy), 1);

    // Asynchronous reset mid-scan clears everything without a clock edge.
    repeat (30) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/delay_scan_sequencer.md
Name: delay_scan_sequencer

Overview:
- Automatic eye-scan controller for the per-link input-delay datapath.
- Links are selected by mask and handled one at a time, lowest index first. For each link the block drives the manual delay-setting controls, sweeps the delay, and measures bit-align errors at each step.
- After the sweep it applies the centre of the widest zero-error window and publishes results for register readback.

Parameters:
NLINKS, 12, number of links sequenced
STEP, 8, delay increment per scan point (1..511)
DELAY_MAX, 511, last delay value scanned (inclusive, <=511)
SETTLE_CYCLES, 16, wait after delay_set rise before sampling delay_ready
DWELL_CYCLES, 1024, error-accumulation window per scan point
RDY_TIMEOUT, 4096, max cycles waiting for delay_ready
ERR_THRESH, 0, max bit_align_errors counted as "good"

Ports:
clk160  in  1  clock, same clock as the IPIF/AXI domain
IPIF_bus2ip_resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin scan (ignored while busy)
abort  in  1  one-cycle pulse; stop scan
link_mask  in  NLINKS  links to scan, latched on start
delay_ready  in  1 x[NLINKS]  per-link delay ready
waiting_for_transitions  in  1 x[NLINKS]  per-link no-transition flag
bit_align_errors  in  16 x[NLINKS]  per-link error counters
scan_delay_in  out  9 x[NLINKS]  manual delay value to datapath
scan_delay_set  out  1 x[NLINKS]  delay-set strobe level to datapath
scan_reset_counters  out  1 x[NLINKS]  error-counter clear to datapath
busy  out  1  scan in progress
done  out  1  one-cycle pulse at scan completion
result_delay  out  9 x[NLINKS]  applied eye-centre delay
result_width  out  9 x[NLINKS]  widest good run, in scan points
result_valid  out  1 x[NLINKS]  link scanned successfully since last start
scan_fail  out  1 x[NLINKS]  no good point found, or ready timeout

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal counters 0.
- The scan always uses manual delay mode; the integrator ties the datapath delay_mode low.
- FSM states: IDLE, NEXT_LINK, APPLY, SET, SETTLE, WAIT_RDY, CLR, DWELL, SAMPLE, FINAL_APPLY, FINAL_SET, FINAL_SETTLE, FINAL_WAIT, DONE.
- IDLE:
  - On start: latch link_mask, clear result_valid and scan_fail for all links, assert busy on the next cycle, go to NEXT_LINK.
- NEXT_LINK:
  - Select the lowest unprocessed masked link and clear its eye trackers (run_start, run_len, best_start, best_len); delay index d=0; go to APPLY.
  - If no masked link remains, go to DONE.
  - Mask of all zeros: done pulses 2 cycles after start.
- APPLY (1 cycle): scan_delay_set[L]=0, scan_delay_in[L]=d.
- SET: scan_delay_set[L]=1. The level is held until the next APPLY or FINAL_APPLY, so the datapath sees a 0->1 edge.
- SETTLE: count SETTLE_CYCLES, then go to WAIT_RDY.
- WAIT_RDY:
  - When delay_ready[L]=1, go to CLR.
  - After RDY_TIMEOUT cycles: scan_fail[L]=1, drive scan_delay_set[L]=0, go to NEXT_LINK (link skipped, result_valid stays 0).
- CLR: scan_reset_counters[L]=1 for exactly 2 cycles.
- DWELL: count DWELL_CYCLES, then go to SAMPLE.
- SAMPLE (1 cycle):
  - A point is good when bit_align_errors[L] <= ERR_THRESH and waiting_for_transitions[L]=0.
  - Good point: if run_len==0 set run_start=d; then run_len+=1.
  - Bad point: if run_len > best_len, copy the run into best; then run_len=0.
  - Strictly greater replaces best, so on ties the lowest-delay run wins.
  - If d+STEP <= DELAY_MAX: d+=STEP, go to APPLY. Otherwise close any open run with the same compare, go to FINAL_APPLY.
  - Sum is computed at 10 bits; no 9-bit wrap.
- Final centre:
  - Centre = best_start + ((best_len-1)*STEP)>>1, computed at 18 bits and clipped to DELAY_MAX.
  - best_len==0: centre=0, scan_fail[L]=1.
- FINAL_APPLY / FINAL_SET / FINAL_SETTLE / FINAL_WAIT:
  - Same handshake as APPLY / SET / SETTLE / WAIT_RDY, using the centre value.
  - On ready: result_delay[L]=centre, result_width[L]=best_len, result_valid[L]=!scan_fail[L], go to NEXT_LINK.
  - Timeout here sets scan_fail[L].
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- abort in any non-IDLE state:
  - Next cycle: IDLE, busy=0, every scan_delay_set and scan_reset_counters driven to 0, no done pulse.
  - scan_delay_in holds its last value; results of completed links are kept.
- abort and start in the same cycle in IDLE: start wins. In non-IDLE states abort wins and start is ignored.
- start while busy: ignored.
- Asynchronous reset mid-scan: immediate return to the reset state.
- Only link L's outputs change during its scan.

Test Plan:
1. NLINKS=2, STEP=64, mask=2'b01; link0 model returns errors=0 at delays 128..320, errors=5 elsewhere -> result_width[0]=4, result_delay[0]=224, result_valid[0]=1, link1 outputs untouched, single done pulse.
2. Two disjoint good runs of equal length (64..128 and 320..384) -> lowest run chosen, result_delay=96.
3. All points with errors=3 -> scan_fail=1, result_valid=0, final scan_delay_in=0, done pulses.
4. delay_ready held 0 on link1, mask=2'b11 -> link1 scan_fail after RDY_TIMEOUT, link0 results valid, done asserted.
5. abort mid-DWELL -> busy low next cycle, scan_delay_set and scan_reset_counters all 0, no done; a new start rescans cleanly.
6. Check every handshake: each APPLY shows scan_delay_set 0 then 1, scan_reset_counters high exactly 2 cycles, no sample taken before DWELL_CYCLES elapse; mask=0 -> done 2 cycles after start.
